// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: state encoding, default width, counter sizing.
package serial_add_ctrl_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    // Bits needed to hold WIDTH-1; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/fa_bit.sv
// One-bit full adder made of two half adders and an OR; purely combinational.
module fa_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    // First half adder on the operands, second on the partial sum and carry-in.
    always_comb begin
        ha0_s = a_i ^ b_i;
        ha0_c = a_i & b_i;
        s_o   = ha0_s ^ c_i;
        ha1_c = ha0_s & c_i;
        c_o   = ha0_c | ha1_c;
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial unsigned adder: one full-adder cell, LSB first, one bit per clock.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int unsigned     CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic [CntW-1:0]  count_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic             cell_s;
    logic             cell_c;

    fa_bit u_fa_bit (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (cell_s),
        .c_o (cell_c)
    );

    // Result vector with the current cell sum dropped into the bit being computed.
    always_comb begin
        sum_d          = sum_q;
        sum_d[count_q] = cell_s;
    end

    // Control FSM plus datapath registers; busy/done are registered alongside the state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        sum_q   <= '0;
                        count_q <= '0;
                        carry_q <= 1'b0;
                        cout_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    sum_q   <= sum_d;
                    carry_q <= cell_c;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    if (count_q == LastCnt) begin
                        // Counter is left at its final value so it never wraps.
                        cout_q  <= cell_c;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed plus randomized bench for serial_add_ctrl; reference result is plain a + b.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int checks   = 0;
    int failures = 0;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk_i   (clk),
        .reset_i (rst),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .busy_o  (busy),
        .done_o  (done),
        .sum_o   (sum),
        .cout_o  (cout)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk_i   (clk),
        .reset_i (rst),
        .start_i (start1),
        .a_i     (a1),
        .b_i     (b1),
        .busy_o  (busy1),
        .done_o  (done1),
        .sum_o   (sum1),
        .cout_o  (cout1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation on the 8-bit instance; optionally scrambles inputs during RUN.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input bit scramble,
                          input string tag);
        logic [8:0] expv;
        int busy_n;
        int done_n;
        int done_at;
        expv = {1'b0, av} + {1'b0, bv};
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at == 0) done_at = k;
            end
            if (scramble) begin
                a     = 8'($urandom);
                b     = 8'($urandom);
                start = (k <= 9) ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, " busy_cycles"}, busy_n, 8);
        check({tag, " done_count"}, done_n, 1);
        check({tag, " done_at"}, done_at, 9);
        check({tag, " sum"}, sum, expv[7:0]);
        check({tag, " cout"}, cout, expv[8]);
    endtask

    initial begin
        logic [7:0] av;
        logic [7:0] bv;
        logic [8:0] expv;
        int busy_n;
        int done_n;
        int done_at;

        rst    = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        #1 rst = 1'b1;
        #2;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", busy, 0);

        // Directed vectors
        run_op(8'h3C, 8'h0F, 1'b0, "3C+0F");
        run_op(8'hFF, 8'h01, 1'b0, "FF+01");
        run_op(8'hFF, 8'hFF, 1'b0, "FF+FF");
        run_op(8'h00, 8'h00, 1'b0, "00+00");
        run_op(8'h5A, 8'hA5, 1'b1, "5A+A5 scrambled");

        // Random operands, every other one with noisy inputs during RUN
        for (int i = 0; i < 12; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'(i % 2), $sformatf("rand%0d", i));
        end

        // Reset during the 4th RUN cycle aborts the operation
        @(negedge clk);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-abort busy", busy, 1);
        check("pre-abort sum partial", sum, 8'h07);
        #2 rst = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort sum", sum, 0);
        check("abort cout", cout, 0);
        @(negedge clk);
        rst    = 1'b0;
        done_n = 0;
        busy_n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) done_n++;
            if (busy) busy_n++;
        end
        check("post-abort done_count", done_n, 0);
        check("post-abort busy_count", busy_n, 0);
        run_op(8'h01, 8'h02, 1'b0, "01+02 after abort");

        // start held high: back-to-back operations with one IDLE cycle between
        av = 8'($urandom);
        bv = 8'($urandom);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        for (int op = 0; op < 4; op++) begin
            expv    = {1'b0, av} + {1'b0, bv};
            busy_n  = 0;
            done_at = 0;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (busy) busy_n++;
                if (done && done_at == 0) done_at = k;
                if (k == 9) begin
                    check($sformatf("held%0d sum", op), sum, expv[7:0]);
                    check($sformatf("held%0d cout", op), cout, expv[8]);
                    if (op < 3) begin
                        av = 8'($urandom);
                        bv = 8'($urandom);
                        a  = av;
                        b  = bv;
                    end else begin
                        start = 1'b0;
                    end
                end
                if (k == 10) begin
                    check($sformatf("held%0d gap busy/done", op), {busy, done}, 2'b00);
                    check($sformatf("held%0d gap sum", op), {cout, sum}, expv);
                end
            end
            check($sformatf("held%0d busy_cycles", op), busy_n, 8);
            check($sformatf("held%0d done_at", op), done_at, 9);
        end

        // Single-bit instance: 1 + 1
        @(negedge clk);
        start1 = 1'b1;
        a1     = 1'b1;
        b1     = 1'b1;
        @(posedge clk);
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (busy1) busy_n++;
            if (done1) begin
                done_n++;
                if (done_at == 0) done_at = k;
            end
        end
        check("w1 busy_cycles", busy_n, 1);
        check("w1 done_count", done_n, 1);
        check("w1 done_at", done_at, 2);
        check("w1 sum", sum1, 0);
        check("w1 cout", cout1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
